regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file. Successor to the fixed 32x32, 2-read/1-write RISC-V register file.
- Configurable XLEN, register count, read-port count and write-port count. Register 0 is hardwired to zero.
- Combinational reads with same-cycle write-through bypass.
- Per-register busy scoreboard (claim on issue, clear on writeback), so the decode stage can stall on pending results.

Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, number of architectural registers; power of two, >=2.
- NREAD, 2, number of read ports.
- NWRITE, 1, number of write ports; 1..4.
- AW (localparam), $clog2(NREGS), address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- raddr  in  NREAD*AW  read addresses; port i at [i*AW +: AW]
- rdata  out  NREAD*XLEN  read data; port i at [i*XLEN +: XLEN]
- rbusy  out  NREAD  busy flag of the register addressed by port i, after bypass
- wen  in  NWRITE  write enables
- waddr  in  NWRITE*AW  write addresses
- wdata  in  NWRITE*XLEN  write data
- claim_en  in  1  mark claim_addr as pending a result
- claim_addr  in  AW  register being claimed
- busy  out  NREGS  registered scoreboard vector; busy[0] is constant 0

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: on a rst-high posedge, all registers are set to 0 and busy is set to 0. rst overrides any same-cycle write or claim.
- After reset: every rdata reads 0 and every rbusy reads 0 until the first write or claim.
- Register 0: reads always return 0. Writes and claims to address 0 are ignored. busy[0] is never set.
- Write:
  - A register updates on the posedge where wen[j]=1 and waddr[j]=r, r!=0.
  - Several ports writing the same address in one cycle: the highest port index wins.
- Read: combinational, zero latency.
  - rdata_i = regs[raddr_i], unless a bypass applies.
  - Bypass: if any wen[j]=1 with waddr[j]=raddr_i!=0, rdata_i = wdata of the highest such j (write-first).
- Scoreboard update, per posedge:
  - busy[r] is set when claim_en=1 and claim_addr=r.
  - Otherwise busy[r] is cleared when any wen[j]=1 with waddr[j]=r.
  - Claim and write to the same r in one cycle: claim wins and busy stays 1 (new producer issued).
  - Claiming an already-busy register leaves it busy.
- rbusy_i is combinational:
  - Equals busy[raddr_i] with write-clear bypass: 0 if a same-cycle write targets raddr_i.
  - The bypass is overridden to 1 if a same-cycle claim also targets raddr_i.
  - Always 0 for raddr_i=0.
- Addresses are always within range (NREGS is a power of two); there is no out-of-range case.
- Reset mid-operation: in-flight claims are discarded. A write presented in the reset cycle is lost.
- X-safety: a wen bit that is 0 must not propagate an X from waddr or wdata.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEFAULT=32 and NREGS_DEFAULT=32.
  - Function rf_aw(n) returning $clog2(n).
  - Typedef reg_addr_t (default width) for decode/issue use.
- Sub-module regfile_read_port, instantiated NREAD times via generate. Per port it contains:
  - the array mux
  - the zero-register force
  - the write-bypass priority select
  - the rbusy computation
- Top level holds the storage array, write-priority logic and scoreboard.

Test Plan:
1. Reset then read: rst=1 for 1 cycle, then raddr0=5, raddr1=31 -> rdata0=0, rdata1=0, rbusy=2'b00, busy=0.
2. Write then read with bypass: wen=1, waddr=7, wdata=32'hDEADBEEF, raddr0=7 in the same cycle -> rdata0=DEADBEEF combinationally. Next cycle with wen=0 -> rdata0 still DEADBEEF.
3. Register 0: wen=1, waddr=0, wdata=32'hFFFFFFFF; claim_en=1, claim_addr=0 -> rdata for raddr=0 is 0 in that cycle and after; busy[0]=0.
4. Dual-write conflict (NWRITE=2): wen=2'b11, both waddr=3, wdata0=32'h1111, wdata1=32'h2222 -> bypass reads 2222; regs[3]=2222 next cycle.
5. Scoreboard:
   - Cycle 1: claim r9 -> busy[9]=1 the next cycle.
   - Cycle 3: write r9 and claim r9 together -> busy[9] stays 1 and rbusy for raddr=9 reads 1.
   - Cycle 4: write r9 alone -> busy[9]=0 the next cycle; rbusy=0 in the write cycle.
6. Reset mid-operation: busy[4]=1, regs[4]=32'hA5; assert rst alongside wen=1, waddr=4 -> next cycle regs[4]=0 and busy[4]=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address helpers for the multi-port register file.
// Imported by the register file and its read ports; no logic of its own.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

  localparam int AW_DEFAULT = rf_aw(NREGS_DEFAULT);

  // Register index as carried through decode/issue.
  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, write-first bypass, x0 force and busy lookup.
// Latency: zero cycles; no backpressure.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NWRITE = 1,
  parameter int AW     = rf_aw(NREGS)
) (
  input  logic [AW-1:0]               raddr,
  input  logic [NREGS-1:0][XLEN-1:0]  regs,
  input  logic [NREGS-1:0]            busy,
  input  logic [NWRITE-1:0]           wen,
  input  logic [NWRITE*AW-1:0]        waddr,
  input  logic [NWRITE*XLEN-1:0]      wdata,
  input  logic                        claim_en,
  input  logic [AW-1:0]               claim_addr,
  output logic [XLEN-1:0]             rdata,
  output logic                        rbusy
);

  always_comb begin
    rdata = regs[raddr];
    rbusy = busy[raddr];
    // Ascending scan so the highest matching write port ends up selected;
    // wen is tested first so a disabled port's address/data cannot leak.
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j] && (waddr[j*AW +: AW] == raddr)) begin
        rdata = wdata[j*XLEN +: XLEN];
        rbusy = 1'b0;
      end
    end
    if (claim_en && (claim_addr == raddr)) begin
      rbusy = 1'b1;
    end
    if (raddr == '0) begin
      rdata = '0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD bypassed read ports, NWRITE write ports and a busy scoreboard.
// Latency: reads combinational, writes/claims visible next cycle; no backpressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  localparam int AW    = rf_aw(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*XLEN-1:0]   rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       wen,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*XLEN-1:0]  wdata,
  input  logic                    claim_en,
  input  logic [AW-1:0]           claim_addr,
  output logic [NREGS-1:0]        busy
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy_q;
  logic [NREGS-1:0]           busy_nxt;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
          regs_q[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Writeback clears, then a same-cycle claim re-sets: the new producer wins.
  always_comb begin
    busy_nxt = busy_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wen[j]) begin
        busy_nxt[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (claim_en) begin
      busy_nxt[claim_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy = busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_read_port #(
      .XLEN   (XLEN),
      .NREGS  (NREGS),
      .NWRITE (NWRITE),
      .AW     (AW)
    ) u_rd (
      .raddr      (raddr[i*AW +: AW]),
      .regs       (regs_q),
      .busy       (busy_q),
      .wen        (wen),
      .waddr      (waddr),
      .wdata      (wdata),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .rdata      (rdata[i*XLEN +: XLEN]),
      .rbusy      (rbusy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios followed by random traffic against an array model.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREAD*AW-1:0]    raddr;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rbusy;
  logic [NWRITE-1:0]      wen;
  logic [NWRITE*AW-1:0]   waddr;
  logic [NWRITE*XLEN-1:0] wdata;
  logic                   claim_en;
  logic [AW-1:0]          claim_addr;
  logic [NREGS-1:0]       busy;

  regfile_mp #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .wen        (wen),
    .waddr      (waddr),
    .wdata      (wdata),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] wa(input int j);
    return waddr[j*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] ra(input int i);
    return raddr[i*AW +: AW];
  endfunction

  // Value a reader of register a should see this cycle: newest writer of a, else stored value.
  function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int j = NWRITE - 1; j >= 0; j--)
      if (wen[j] && wa(j) == a) return wdata[j*XLEN +: XLEN];
    return m_regs[a];
  endfunction

  function automatic logic exp_rbusy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (claim_en && claim_addr == a) return 1'b1;
    for (int j = 0; j < NWRITE; j++)
      if (wen[j] && wa(j) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [NREGS-1:0] exp_busy_vec();
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NREAD; i++) begin
      chk($sformatf("rdata%0d", i), rdata[i*XLEN +: XLEN], exp_rdata(ra(i)));
      chk($sformatf("rbusy%0d", i), rbusy[i], exp_rbusy(ra(i)));
    end
    chk("busy", busy, exp_busy_vec());
  endtask

  task automatic model_update();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int j = 0; j < NWRITE; j++)
        if (wen[j] && wa(j) != 0) m_regs[wa(j)] = wdata[j*XLEN +: XLEN];
      for (int j = 0; j < NWRITE; j++)
        if (wen[j]) m_busy[wa(j)] = 1'b0;
      if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    end
  endtask

  // Inputs are set at the negedge; outputs checked 1 time unit later, model advanced at posedge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    #1 model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; wen = '0; waddr = '0; wdata = '0; claim_en = 1'b0; claim_addr = '0;
  endtask

  initial begin
    idle();
    raddr = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 model_update();
    @(negedge clk);

    // Reset state
    idle();
    raddr = {5'd31, 5'd5};
    #1;
    chk("t1_rdata0", rdata[31:0], 32'h0);
    chk("t1_rdata1", rdata[63:32], 32'h0);
    chk("t1_rbusy", rbusy, 2'b00);
    chk("t1_busy", busy, 32'h0);
    step();

    // Write-first bypass, then stored value
    wen = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hDEADBEEF}; raddr = {5'd0, 5'd7};
    #1 chk("t2_bypass", rdata[31:0], 32'hDEADBEEF);
    step();
    idle();
    #1 chk("t2_stored", rdata[31:0], 32'hDEADBEEF);
    step();

    // Register 0 ignores writes and claims
    wen = 2'b01; waddr = '0; wdata = {32'h0, 32'hFFFFFFFF}; claim_en = 1'b1; claim_addr = '0;
    raddr = '0;
    #1 chk("t3_x0_same", rdata[31:0], 32'h0);
    step();
    idle();
    #1;
    chk("t3_x0_after", rdata[31:0], 32'h0);
    chk("t3_busy0", busy[0], 1'b0);
    step();

    // Same-address dual write: port 1 wins
    wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h2222, 32'h1111}; raddr = {5'd0, 5'd3};
    #1 chk("t4_bypass", rdata[31:0], 32'h2222);
    step();
    idle();
    #1 chk("t4_stored", rdata[31:0], 32'h2222);
    step();

    // Scoreboard claim / claim+write / write
    claim_en = 1'b1; claim_addr = 5'd9; raddr = {5'd0, 5'd9};
    #1 chk("t5_claim_rbusy", rbusy[0], 1'b1);
    step();
    idle();
    #1 chk("t5_busy9_set", busy[9], 1'b1);
    step();
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99}; claim_en = 1'b1; claim_addr = 5'd9;
    #1 chk("t5_claimwr_rbusy", rbusy[0], 1'b1);
    step();
    idle();
    wen = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h9A};
    #1;
    chk("t5_busy9_kept", busy[9], 1'b1);
    chk("t5_wr_rbusy", rbusy[0], 1'b0);
    step();
    idle();
    #1 chk("t5_busy9_clr", busy[9], 1'b0);
    step();

    // Reset mid-operation discards the write and the claim
    wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'hA5}; claim_en = 1'b1; claim_addr = 5'd4;
    raddr = {5'd0, 5'd4};
    step();
    idle();
    #1;
    chk("t6_busy4_pre", busy[4], 1'b1);
    chk("t6_regs4_pre", rdata[31:0], 32'hA5);
    rst = 1'b1; wen = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h1234};
    step();
    idle();
    #1;
    chk("t6_regs4_rst", rdata[31:0], 32'h0);
    chk("t6_busy4_rst", busy[4], 1'b0);
    step();

    // Random traffic; narrow address range forces collisions
    for (int n = 0; n < 600; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREAD; i++)
        raddr[i*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
      for (int j = 0; j < NWRITE; j++) begin
        wen[j] = ($urandom_range(0, 2) != 0);
        if (wen[j] || $urandom_range(0, 1) == 0) begin
          waddr[j*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
          wdata[j*XLEN +: XLEN] = $urandom;
        end else begin
          waddr[j*AW +: AW] = 'x;
          wdata[j*XLEN +: XLEN] = 'x;
        end
      end
      claim_en = ($urandom_range(0, 2) == 0);
      claim_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
